// File: rtl/fifo_burst_reader.sv
// Read-side burst controller for a registered-output synchronous FIFO: drains burst_len words
// onto a valid/ready stream through a 2-entry skid buffer. Optional stall counter: FBR_STALL_STATS_EN.
module fifo_burst_reader #(
   parameter int FIFO_WIDTH = 32,
   parameter int LEN_W      = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [LEN_W-1:0]      burst_len,
   input  logic                  flush,
   output logic                  busy,
   output logic                  done,
   output logic                  fifo_read_en,
   input  logic                  fifo_empty,
   input  logic [FIFO_WIDTH-1:0] fifo_read_data,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [FIFO_WIDTH-1:0] m_data,
   output logic                  m_last
`ifdef FBR_STALL_STATS_EN
   ,
   output logic [15:0]           stall_cycles
`endif
);

   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

   state_t                state, state_nxt;
   logic [LEN_W-1:0]      len_q;
   logic [LEN_W-1:0]      issue_cnt;
   logic [LEN_W-1:0]      beat_cnt;
   logic                  zlen_done;
   logic                  pend_p1;
   logic [1:0]            buf_cnt_p2;
   logic [FIFO_WIDTH-1:0] buf0_p2;
   logic [FIFO_WIDTH-1:0] buf1_p2;

   logic       run;
   logic       pop;
   logic       start_ok;
   logic [2:0] occ_nxt;

   assign run      = (state == ST_RUN);
   assign pop      = m_valid && m_ready;
   assign start_ok = (state == ST_IDLE) && start;
   // pop can only happen with buf_cnt_p2 >= 1, so this never underflows
   assign occ_nxt  = {1'b0, buf_cnt_p2} + {2'b00, pend_p1} - {2'b00, pop};

   assign fifo_read_en = run && !flush && !fifo_empty && (issue_cnt < len_q) && (occ_nxt < 3'd2);

   assign m_valid = (buf_cnt_p2 != 2'd0);
   assign m_data  = buf0_p2;
   assign m_last  = m_valid && (beat_cnt == len_q - LEN_W'(1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (start && (burst_len != '0)) state_nxt = ST_RUN;
         ST_RUN: begin
            if (flush)                state_nxt = ST_IDLE;
            else if (pop && m_last)   state_nxt = ST_DONE;
         end
         ST_DONE: state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      busy = (state == ST_RUN);
      done = (state == ST_DONE) || zlen_done;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         len_q     <= '0;
         issue_cnt <= '0;
         beat_cnt  <= '0;
         zlen_done <= 1'b0;
      end else begin
         zlen_done <= start_ok && (burst_len == '0);
         if (start_ok && (burst_len != '0)) begin
            len_q     <= burst_len;
            issue_cnt <= '0;
            beat_cnt  <= '0;
         end else begin
            if (fifo_read_en) issue_cnt <= issue_cnt + LEN_W'(1);
            if (pop)          beat_cnt  <= beat_cnt + LEN_W'(1);
         end
      end
   end

   // p1: read issued last cycle, data on fifo_read_data now; p2: buffered, head drives m_data
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pend_p1    <= 1'b0;
         buf_cnt_p2 <= 2'd0;
         buf0_p2    <= '0;
         buf1_p2    <= '0;
      end else if (run && flush) begin
         pend_p1    <= 1'b0;
         buf_cnt_p2 <= 2'd0;
      end else begin
         pend_p1 <= fifo_read_en;
         case ({pop, pend_p1})
            2'b10: begin
               buf0_p2    <= buf1_p2;
               buf_cnt_p2 <= buf_cnt_p2 - 2'd1;
            end
            2'b01: begin
               if (buf_cnt_p2 == 2'd0) buf0_p2 <= fifo_read_data;
               else                    buf1_p2 <= fifo_read_data;
               buf_cnt_p2 <= buf_cnt_p2 + 2'd1;
            end
            2'b11: begin
               if (buf_cnt_p2 == 2'd1) begin
                  buf0_p2 <= fifo_read_data;
               end else begin
                  buf0_p2 <= buf1_p2;
                  buf1_p2 <= fifo_read_data;
               end
            end
            default: ;
         endcase
      end
   end

`ifdef FBR_STALL_STATS_EN
   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                              stall_cycles <= 16'd0;
      else if (start_ok)                    stall_cycles <= 16'd0;
      else if (run && m_valid && !m_ready)  stall_cycles <= sat_inc16(stall_cycles);
   end
`endif

   // the issue rule leaves room for the returning word, so a full buffer never sees pend
   a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(pend_p1 && (buf_cnt_p2 == 2'd2)));

endmodule
